// File: rtl/bus_packet_issuer_if.sv
// rtl/bus_packet_issuer_if.sv - command, packet, response and status bundle for bus_packet_issuer
//
// master modport: the issuer side (drives cmd_ready, pkt_*, done_*, state).
// slave modport : the environment side (drives cmd_*, pkt_ready, rsp_*, err_clear).
interface bus_packet_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;

    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_id;
    logic [1:0]  pkt_op;
    logic [7:0]  pkt_addr;
    logic [31:0] pkt_data;

    logic        rsp_valid;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        done_valid;
    logic [3:0]  done_id;
    logic [31:0] done_data;
    logic        done_err;

    logic [1:0]  state;
    logic        err_clear;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready,
        output pkt_valid, pkt_id, pkt_op, pkt_addr, pkt_data,
        input  pkt_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output done_valid, done_id, done_data, done_err,
        output state,
        input  err_clear
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  pkt_valid, pkt_id, pkt_op, pkt_addr, pkt_data,
        output pkt_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  done_valid, done_id, done_data, done_err,
        input  state,
        output err_clear
    );
endinterface

// File: rtl/bus_packet_issuer.sv
// rtl/bus_packet_issuer.sv - single-outstanding command-to-bus issue stage with ID tagging and response timeout
//
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous active-low reset
//   bus  - bus_packet_issuer_if.master: command in (cmd_*), request packet out (pkt_*),
//          response in (rsp_*), completion pulse out (done_*), state out, err_clear in
// Parameters:
//   TIMEOUT_CYCLES - cycles in WAIT without a matching response before ERROR (>= 2)
module bus_packet_issuer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_packet_issuer_if.master    bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      next_id;
    logic [TW-1:0]   timer;

    logic [3:0]      pkt_id_q;
    logic [1:0]      pkt_op_q;
    logic [7:0]      pkt_addr_q;
    logic [31:0]     pkt_data_q;

    logic            done_valid_q, done_valid_d;
    logic [3:0]      done_id_q,    done_id_d;
    logic [31:0]     done_data_q,  done_data_d;
    logic            done_err_q,   done_err_d;

    logic            cmd_ready_int;
    logic            accept;
    logic            illegal;
    logic            pkt_fire;
    logic            rsp_match;
    logic            timeout;

    assign accept    = bus.cmd_valid && cmd_ready_int;
    assign illegal   = (bus.cmd_op == OP_ILLEGAL);
    assign pkt_fire  = (state_q == S_ACTIVE) && bus.pkt_ready;
    // Responses only count in WAIT, so one arriving alongside the packet handshake is dropped.
    assign rsp_match = (state_q == S_WAIT) && bus.rsp_valid && (bus.rsp_id == pkt_id_q);
    assign timeout   = (state_q == S_WAIT) && (timer == TW'(TIMEOUT_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            next_id      <= 4'd0;
            timer        <= '0;
            pkt_id_q     <= 4'd0;
            pkt_op_q     <= 2'd0;
            pkt_addr_q   <= 8'd0;
            pkt_data_q   <= 32'd0;
            done_valid_q <= 1'b0;
            done_id_q    <= 4'd0;
            done_data_q  <= 32'd0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_data_q  <= done_data_d;
            done_err_q   <= done_err_d;

            if (accept && !illegal) begin
                pkt_id_q   <= next_id;
                pkt_op_q   <= bus.cmd_op;
                pkt_addr_q <= bus.cmd_addr;
                pkt_data_q <= (bus.cmd_op == OP_WRITE) ? bus.cmd_wdata : 32'd0;
            end

            // The ID advances only once a packet actually leaves, so an illegal op
            // does not consume one.
            if (pkt_fire) begin
                timer   <= '0;
                next_id <= next_id + 4'd1;
            end else if (state_q == S_WAIT) begin
                timer   <= timer + TW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = illegal ? S_ERROR : S_ACTIVE;
            S_ACTIVE: if (bus.pkt_ready) state_d = S_WAIT;
            // Match is checked first so it wins over a coincident timeout.
            S_WAIT:   if (rsp_match) state_d = S_IDLE;
                      else if (timeout) state_d = S_ERROR;
            S_ERROR:  if (bus.err_clear) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: ready decode and next values of the completion registers
    always_comb begin
        cmd_ready_int = (state_q == S_IDLE) && rst;
        done_valid_d  = 1'b0;
        done_id_d     = 4'd0;
        done_data_d   = 32'd0;
        done_err_d    = 1'b0;
        if (accept && illegal) begin
            done_valid_d = 1'b1;
            done_id_d    = next_id;
            done_err_d   = 1'b1;
        end else if (rsp_match) begin
            done_valid_d = 1'b1;
            done_id_d    = pkt_id_q;
            done_data_d  = bus.rsp_data;
            done_err_d   = bus.rsp_err;
        end else if (timeout) begin
            done_valid_d = 1'b1;
            done_id_d    = pkt_id_q;
            done_err_d   = 1'b1;
        end
    end

    assign bus.cmd_ready  = cmd_ready_int;
    assign bus.pkt_valid  = (state_q == S_ACTIVE);
    assign bus.pkt_id     = pkt_id_q;
    assign bus.pkt_op     = pkt_op_q;
    assign bus.pkt_addr   = pkt_addr_q;
    assign bus.pkt_data   = pkt_data_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_data  = done_data_q;
    assign bus.done_err   = done_err_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_bus_packet_issuer.sv
// tb/tb_bus_packet_issuer.sv - directed self-checking bench for bus_packet_issuer
module tb_bus_packet_issuer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    bus_packet_issuer_if bus();

    bus_packet_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 8'd0; bus.cmd_wdata = 32'd0;
        bus.pkt_ready = 1'b0;
        bus.rsp_valid = 1'b0; bus.rsp_id = 4'd0; bus.rsp_data = 32'd0; bus.rsp_err = 1'b0;
        bus.err_clear = 1'b0;
        step; step;
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        tests++; if ({bus.pkt_valid, bus.done_valid, bus.done_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bus.pkt_valid, bus.done_valid, bus.done_err}); end
        tests++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        tests++; if ({bus.pkt_id, bus.pkt_addr, bus.pkt_data, bus.done_id, bus.done_data} !== 80'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {bus.pkt_id, bus.pkt_addr, bus.pkt_data, bus.done_id, bus.done_data}); end
        rst = 1'b1;
        #1;
        tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL release_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_read;
        drive_cmd(2'd0, 8'h10, 32'h1234_5678);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if ({bus.pkt_valid, bus.pkt_id, bus.pkt_op, bus.pkt_addr, bus.pkt_data} !== {1'b1, 4'd0, 2'd0, 8'h10, 32'd0}) begin fails++; $display("FAIL read_pkt: got %h want %h", {bus.pkt_valid, bus.pkt_id, bus.pkt_op, bus.pkt_addr, bus.pkt_data}, {1'b1, 4'd0, 2'd0, 8'h10, 32'd0}); end
        tests++; if ({bus.state, bus.cmd_ready} !== {2'd1, 1'b0}) begin fails++; $display("FAIL read_active: got %b want 010", {bus.state, bus.cmd_ready}); end
        bus.pkt_ready = 1'b1;
        step;
        bus.pkt_ready = 1'b0;
        tests++; if ({bus.state, bus.pkt_valid} !== {2'd2, 1'b0}) begin fails++; $display("FAIL read_wait: got %b want 100", {bus.state, bus.pkt_valid}); end
        bus.rsp_valid = 1'b1; bus.rsp_id = 4'd0; bus.rsp_data = 32'hDEAD_BEEF; bus.rsp_err = 1'b0;
        step;
        bus.rsp_valid = 1'b0;
        tests++; if ({bus.done_valid, bus.done_id, bus.done_data, bus.done_err} !== {1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0}) begin fails++; $display("FAIL read_done: got %h want %h", {bus.done_valid, bus.done_id, bus.done_data, bus.done_err}, {1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0}); end
        tests++; if ({bus.state, bus.cmd_ready} !== {2'd0, 1'b1}) begin fails++; $display("FAIL read_idle: got %b want 001", {bus.state, bus.cmd_ready}); end
        step;
        tests++; if (bus.done_valid !== 1'b0) begin fails++; $display("FAIL read_done_pulse: got %b want 0", bus.done_valid); end
    endtask

    task automatic test_backpressure;
        drive_cmd(2'd1, 8'hFF, 32'hDEAD_BEEF);
        step;
        bus.cmd_valid = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tests++; if ({bus.pkt_valid, bus.pkt_id, bus.pkt_op, bus.pkt_addr, bus.pkt_data} !== {1'b1, 4'd1, 2'd1, 8'hFF, 32'hDEAD_BEEF}) begin fails++; $display("FAIL bp_stable[%0d]: got %h want %h", i, {bus.pkt_valid, bus.pkt_id, bus.pkt_op, bus.pkt_addr, bus.pkt_data}, {1'b1, 4'd1, 2'd1, 8'hFF, 32'hDEAD_BEEF}); end
            step;
        end
        bus.pkt_ready = 1'b1;
        step;
        bus.pkt_ready = 1'b0;
        bus.rsp_valid = 1'b1; bus.rsp_id = 4'd1; bus.rsp_data = 32'h0000_CAFE; bus.rsp_err = 1'b0;
        step;
        bus.rsp_valid = 1'b0;
        tests++; if ({bus.done_valid, bus.done_id, bus.done_data, bus.done_err} !== {1'b1, 4'd1, 32'h0000_CAFE, 1'b0}) begin fails++; $display("FAIL bp_done: got %h want %h", {bus.done_valid, bus.done_id, bus.done_data, bus.done_err}, {1'b1, 4'd1, 32'h0000_CAFE, 1'b0}); end
    endtask

    task automatic test_mismatch;
        drive_cmd(2'd0, 8'h20, 32'h0);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if (bus.pkt_id !== 4'd2) begin fails++; $display("FAIL mm_pkt_id: got %0d want 2", bus.pkt_id); end
        // A matching response during the handshake cycle must be ignored.
        bus.pkt_ready = 1'b1;
        bus.rsp_valid = 1'b1; bus.rsp_id = 4'd2; bus.rsp_data = 32'h111; bus.rsp_err = 1'b0;
        step;
        bus.pkt_ready = 1'b0;
        tests++; if ({bus.state, bus.done_valid} !== {2'd2, 1'b0}) begin fails++; $display("FAIL mm_early_rsp: got %b want 100", {bus.state, bus.done_valid}); end
        bus.rsp_id = 4'hA; bus.rsp_data = 32'h222;
        step;
        tests++; if ({bus.state, bus.done_valid} !== {2'd2, 1'b0}) begin fails++; $display("FAIL mm_wrong_id: got %b want 100", {bus.state, bus.done_valid}); end
        bus.rsp_id = 4'd2; bus.rsp_data = 32'h333; bus.rsp_err = 1'b1;
        step;
        bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
        tests++; if ({bus.done_valid, bus.done_id, bus.done_data, bus.done_err, bus.state} !== {1'b1, 4'd2, 32'h333, 1'b1, 2'd0}) begin fails++; $display("FAIL mm_done: got %h want %h", {bus.done_valid, bus.done_id, bus.done_data, bus.done_err, bus.state}, {1'b1, 4'd2, 32'h333, 1'b1, 2'd0}); end
        step;
        tests++; if (bus.done_valid !== 1'b0) begin fails++; $display("FAIL mm_single_pulse: got %b want 0", bus.done_valid); end
    endtask

    // Transactions 4..17 back to back with pkt_ready held high; the 17th carries ID 0.
    task automatic test_id_wrap;
        logic [3:0] exp_id;
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            exp_id = 4'(3 + i);
            drive_cmd(2'd2, 8'(i), 32'hFFFF_FFFF);
            step;
            bus.cmd_valid = 1'b0;
            tests++; if ({bus.pkt_valid, bus.pkt_id, bus.pkt_data} !== {1'b1, exp_id, 32'd0}) begin fails++; $display("FAIL wrap_pkt[%0d]: got %h want %h", i, {bus.pkt_valid, bus.pkt_id, bus.pkt_data}, {1'b1, exp_id, 32'd0}); end
            step;
            bus.rsp_valid = 1'b1; bus.rsp_id = exp_id; bus.rsp_data = 32'(i);
            step;
            bus.rsp_valid = 1'b0;
            tests++; if ({bus.done_valid, bus.done_id, bus.cmd_ready} !== {1'b1, exp_id, 1'b1}) begin fails++; $display("FAIL wrap_done[%0d]: got %b want %b", i, {bus.done_valid, bus.done_id, bus.cmd_ready}, {1'b1, exp_id, 1'b1}); end
        end
        bus.pkt_ready = 1'b0;
    endtask

    task automatic test_timeout;
        drive_cmd(2'd0, 8'h30, 32'h0);
        step;
        bus.cmd_valid = 1'b0;
        bus.pkt_ready = 1'b1;
        step;
        bus.pkt_ready = 1'b0;
        tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL to_enter_wait: got %0d want 2", bus.state); end
        bus.err_clear = 1'b1;
        step;
        bus.err_clear = 1'b0;
        tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL to_err_clear_in_wait: got %0d want 2", bus.state); end
        for (int k = 2; k < 16; k++) begin
            step;
            tests++; if ({bus.state, bus.done_valid} !== {2'd2, 1'b0}) begin fails++; $display("FAIL to_still_wait[%0d]: got %b want 100", k, {bus.state, bus.done_valid}); end
        end
        step;
        tests++; if ({bus.state, bus.cmd_ready, bus.pkt_valid} !== {2'd3, 1'b0, 1'b0}) begin fails++; $display("FAIL to_error: got %b want 1100", {bus.state, bus.cmd_ready, bus.pkt_valid}); end
        tests++; if ({bus.done_valid, bus.done_id, bus.done_data, bus.done_err} !== {1'b1, 4'd1, 32'd0, 1'b1}) begin fails++; $display("FAIL to_done: got %h want %h", {bus.done_valid, bus.done_id, bus.done_data, bus.done_err}, {1'b1, 4'd1, 32'd0, 1'b1}); end
        step;
        tests++; if ({bus.state, bus.done_valid} !== {2'd3, 1'b0}) begin fails++; $display("FAIL to_hold_error: got %b want 110", {bus.state, bus.done_valid}); end
        bus.err_clear = 1'b1;
        step;
        bus.err_clear = 1'b0;
        tests++; if ({bus.state, bus.cmd_ready} !== {2'd0, 1'b1}) begin fails++; $display("FAIL to_clear: got %b want 001", {bus.state, bus.cmd_ready}); end
    endtask

    task automatic test_illegal;
        drive_cmd(2'd3, 8'h55, 32'h1);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if ({bus.state, bus.pkt_valid, bus.cmd_ready} !== {2'd3, 1'b0, 1'b0}) begin fails++; $display("FAIL ill_state: got %b want 1100", {bus.state, bus.pkt_valid, bus.cmd_ready}); end
        tests++; if ({bus.done_valid, bus.done_id, bus.done_data, bus.done_err} !== {1'b1, 4'd2, 32'd0, 1'b1}) begin fails++; $display("FAIL ill_done: got %h want %h", {bus.done_valid, bus.done_id, bus.done_data, bus.done_err}, {1'b1, 4'd2, 32'd0, 1'b1}); end
        step;
        tests++; if ({bus.pkt_valid, bus.done_valid} !== 2'b00) begin fails++; $display("FAIL ill_no_pkt: got %b want 00", {bus.pkt_valid, bus.done_valid}); end
        bus.err_clear = 1'b1;
        step;
        bus.err_clear = 1'b0;
        tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL ill_clear: got %0d want 0", bus.state); end
    endtask

    task automatic test_timeout_tie;
        drive_cmd(2'd0, 8'h40, 32'h0);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if (bus.pkt_id !== 4'd2) begin fails++; $display("FAIL tie_id_unchanged: got %0d want 2", bus.pkt_id); end
        bus.pkt_ready = 1'b1;
        step;
        bus.pkt_ready = 1'b0;
        repeat (15) step;
        tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL tie_pre_wait: got %0d want 2", bus.state); end
        bus.rsp_valid = 1'b1; bus.rsp_id = 4'd2; bus.rsp_data = 32'h77; bus.rsp_err = 1'b1;
        step;
        bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
        tests++; if ({bus.state, bus.done_valid, bus.done_id, bus.done_data, bus.done_err} !== {2'd0, 1'b1, 4'd2, 32'h77, 1'b1}) begin fails++; $display("FAIL tie_match_wins: got %h want %h", {bus.state, bus.done_valid, bus.done_id, bus.done_data, bus.done_err}, {2'd0, 1'b1, 4'd2, 32'h77, 1'b1}); end
    endtask

    task automatic test_reset_active;
        drive_cmd(2'd0, 8'h50, 32'h0);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if ({bus.pkt_valid, bus.pkt_id} !== {1'b1, 4'd3}) begin fails++; $display("FAIL ra_active: got %b want 10011", {bus.pkt_valid, bus.pkt_id}); end
        rst = 1'b0;
        step;
        rst = 1'b1;
        tests++; if ({bus.pkt_valid, bus.state, bus.done_valid} !== {1'b0, 2'd0, 1'b0}) begin fails++; $display("FAIL ra_reset: got %b want 0000", {bus.pkt_valid, bus.state, bus.done_valid}); end
        step;
        tests++; if (bus.done_valid !== 1'b0) begin fails++; $display("FAIL ra_no_done: got %b want 0", bus.done_valid); end
        drive_cmd(2'd0, 8'h60, 32'h0);
        step;
        bus.cmd_valid = 1'b0;
        tests++; if ({bus.pkt_valid, bus.pkt_id} !== {1'b1, 4'd0}) begin fails++; $display("FAIL ra_id_restart: got %b want 10000", {bus.pkt_valid, bus.pkt_id}); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_read;
        test_backpressure;
        test_mismatch;
        test_id_wrap;
        test_timeout;
        test_illegal;
        test_timeout_tie;
        test_reset_active;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
